// File: rtl/mult_pkg.sv
// Shared sizing for the shift-and-add multiplier datapath.
package mult_pkg;
    localparam int WIDTH = 4;
    localparam int REG_W = 2 * WIDTH + 1;
endpackage

// File: rtl/regs_if.sv
// Controller <-> register bank signals of the shift-and-add multiplier.
interface regs_if;
    import mult_pkg::*;

    logic             ADD;
    logic             SHIFT;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] multiplier;
    logic [REG_W-1:0] register;

    // Controller/adder side drives the commands and adder result.
    modport master (
        output ADD, SHIFT, sum, carry, multiplier,
        input  register
    );

    // Register bank side.
    modport slave (
        input  ADD, SHIFT, sum, carry, multiplier,
        output register
    );
endinterface

// File: rtl/regs.sv
// Register bank {carry, accumulator, multiplier} of the shift-and-add multiplier.
module regs
    import mult_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    regs_if.slave bus
);

    logic [REG_W-1:0] register_q;
    logic [REG_W-1:0] register_d;

    // Next state: ADD beats SHIFT; neither means hold.
    always_comb begin
        register_d = register_q;
        if (bus.ADD) begin
            register_d = {bus.carry, bus.sum, register_q[WIDTH-1:0]};
        end else if (bus.SHIFT) begin
            register_d = {1'b0, register_q[REG_W-1:1]};
        end
    end

    // State register; reset reloads the multiplier and clears carry/accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            register_q <= {{(WIDTH + 1){1'b0}}, bus.multiplier};
        end else begin
            register_q <= register_d;
        end
    end

    assign bus.register = register_q;

endmodule

// File: tb/tb_regs.sv
// Scoreboard bench for the multiplier register bank.
module tb_regs;
    import mult_pkg::*;

    logic clk = 1'b0;
    logic reset;

    regs_if bus ();

    regs dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [REG_W-1:0] exp_q[$];
    string            name_q[$];
    int               n_vec  = 0;
    int               n_miss = 0;

    // Monitor: the register settles after each rising edge; compare on the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [REG_W-1:0] e;
            string            nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if (bus.register !== e) begin
                n_miss++;
                $display("FAIL %s: register=%b expected=%b", nm, bus.register, e);
            end
        end
    end

    // Drive one edge of stimulus; optionally queue the value expected after it.
    task automatic step(input logic r, input logic a, input logic s,
                        input logic [WIDTH-1:0] sm, input logic c,
                        input logic [WIDTH-1:0] m, input logic chk,
                        input logic [REG_W-1:0] e, input string nm);
        reset          = r;
        bus.ADD        = a;
        bus.SHIFT      = s;
        bus.sum        = sm;
        bus.carry      = c;
        bus.multiplier = m;
        @(posedge clk);
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(negedge clk);
    endtask

    // Model controller: WIDTH rounds of conditional add then shift.
    task automatic multiply(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [REG_W-1:0] e, input string nm);
        logic [WIDTH:0] t;
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, b, 1'b0, '0, nm);
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.register[0]) begin
                t = {1'b0, bus.register[2*WIDTH-1:WIDTH]} + {1'b0, a};
                step(1'b0, 1'b1, 1'b0, t[WIDTH-1:0], t[WIDTH], b, 1'b0, '0, nm);
            end
            step(1'b0, 1'b0, 1'b1, '0, 1'b0, b, (i == WIDTH - 1), e, nm);
        end
    endtask

    initial begin
        reset          = 1'b0;
        bus.ADD        = 1'b0;
        bus.SHIFT      = 1'b0;
        bus.sum        = '0;
        bus.carry      = 1'b0;
        bus.multiplier = '0;
        @(negedge clk);

        step(1, 0, 0, 4'd8, 1, 4'd9, 1, 9'b0_0000_1001, "reset_load");
        step(0, 1, 0, 4'd8, 1, 4'd9, 1, 9'b1_1000_1001, "add");
        step(0, 0, 1, 4'd8, 1, 4'd9, 1, 9'b0_1100_0100, "shift");
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 4'd5, 1, 4'd2, 1, 9'b0_1100_0100, "hold");
        step(0, 1, 1, 4'd3, 0, 4'd9, 1, 9'b0_0011_0100, "add_beats_shift");
        step(1, 1, 1, 4'd7, 1, 4'd9, 1, 9'b0_0000_1001, "reset_priority");
        step(0, 0, 1, 4'd0, 0, 4'd9, 1, 9'b0_0000_0100, "shift_lsb_drop");
        step(0, 1, 0, 4'hF, 1, 4'd9, 1, 9'b1_1111_0100, "add_carry");
        step(0, 0, 1, 4'd0, 0, 4'd9, 1, 9'b0_1111_1010, "carry_shift_down");
        step(0, 0, 1, 4'd0, 0, 4'd9, 1, 9'b0_0111_1101, "zero_fill");

        multiply(4'd13, 4'd11, {1'b0, 8'd143}, "mul_13x11");
        multiply(4'd15, 4'd15, {1'b0, 8'd225}, "mul_15x15");
        multiply(4'd0,  4'd7,  {1'b0, 8'd0},   "mul_0x7");

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d pending expected values, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: stimulus incomplete after 100000 time units, required completion");
        $fatal(1, "timeout");
    end

endmodule
